// File: rtl/pci_cfg_initiator.sv
// PCI Type-0 configuration-cycle initiator: one single-data-phase config read or write per host request.
// Define PCI_CFG_TIMEOUT_EN to terminate with target abort when a claiming target never gives TRDY#/STOP#.
module pci_cfg_initiator #(
    parameter int ABORT_CLKS = 5,
    parameter int TRDY_LIMIT = 16
) (
    input  logic        pci_clk_i,
    input  logic        pci_rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  dev_i,
    input  logic [5:0]  reg_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic        pci_frame_no,
    output logic        pci_irdy_no,
    output logic [3:0]  pci_cbe_no,
    output logic        pci_cbe_oe_o,
    output logic [31:0] pci_ad_o,
    output logic        pci_ad_oe_o,
    input  logic [31:0] pci_ad_i,
    output logic        pci_idsel_o,
    input  logic        pci_devsel_ni,
    input  logic        pci_trdy_ni,
    input  logic        pci_stop_ni
);
    // state | meaning
    // IDLE  | bus released, waiting for req_i
    // ADDR  | address phase: FRAME# low, Type-0 address and config command driven
    // DATA  | single data phase: IRDY# low, waiting for a termination
    // TURN  | turnaround: bus released, ack_o pulses with status

    localparam int TMR_MAX = (ABORT_CLKS > TRDY_LIMIT) ? ABORT_CLKS : TRDY_LIMIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] ABORT_LOAD = TMR_W'(ABORT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [3:0]         dev_q, dev_d;
    logic [5:0]         reg_q, reg_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               devsel_seen_q, devsel_seen_d;
    logic [TMR_W-1:0]   abort_tmr_q, abort_tmr_d;
    logic [1:0]         err_d;
    logic [31:0]        rdata_d;
    logic               frame_d, irdy_d, cbe_oe_d, ad_oe_d, idsel_d, busy_d, ack_d;
    logic [3:0]         cbe_d;
    logic [31:0]        ad_d;
`ifdef PCI_CFG_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TRDY_LOAD = TMR_W'(TRDY_LIMIT - 1);
    logic [TMR_W-1:0]   trdy_tmr_q, trdy_tmr_d;
`endif

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        dev_d         = dev_q;
        reg_d         = reg_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        devsel_seen_d = devsel_seen_q;
        abort_tmr_d   = abort_tmr_q;
        err_d         = err_o;
        rdata_d       = rdata_o;
`ifdef PCI_CFG_TIMEOUT_EN
        trdy_tmr_d    = trdy_tmr_q;
`endif

        unique case (state_q)
            IDLE: begin
                devsel_seen_d = 1'b0;
                abort_tmr_d   = ABORT_LOAD;
`ifdef PCI_CFG_TIMEOUT_EN
                trdy_tmr_d    = TRDY_LOAD;
`endif
                if (req_i) begin
                    we_d    = we_i;
                    dev_d   = dev_i;
                    reg_d   = reg_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                if (!pci_devsel_ni) begin
                    devsel_seen_d = 1'b1;
                end
                if (!pci_devsel_ni && !pci_trdy_ni) begin
                    err_d = 2'b00;
                    if (!we_q) begin
                        rdata_d = pci_ad_i;
                    end
                    state_d = TURN;
                end else if (!pci_devsel_ni && !pci_stop_ni) begin
                    err_d   = 2'b10;
                    state_d = TURN;
                end else if (pci_devsel_ni && !pci_stop_ni && devsel_seen_q) begin
                    err_d   = 2'b11;
                    state_d = TURN;
                end else if (pci_devsel_ni && !devsel_seen_q) begin
                    // nobody has claimed yet: run out the decode window
                    if (abort_tmr_q == '0) begin
                        err_d   = 2'b01;
                        rdata_d = 32'hFFFF_FFFF;
                        state_d = TURN;
                    end else begin
                        abort_tmr_d = abort_tmr_q - TMR_W'(1);
                    end
                end
`ifdef PCI_CFG_TIMEOUT_EN
                else if (trdy_tmr_q == '0) begin
                    err_d   = 2'b11;
                    rdata_d = 32'hFFFF_FFFF;
                    state_d = TURN;
                end else begin
                    trdy_tmr_d = trdy_tmr_q - TMR_W'(1);
                end
`endif
            end
            TURN: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // bus outputs are registered from the next state so they change cleanly on the clock edge
        frame_d  = 1'b1;
        irdy_d   = 1'b1;
        cbe_d    = 4'hF;
        cbe_oe_d = 1'b0;
        ad_d     = 32'h0;
        ad_oe_d  = 1'b0;
        idsel_d  = 1'b0;
        busy_d   = (state_d != IDLE);
        ack_d    = (state_d == TURN);

        unique case (state_d)
            ADDR: begin
                frame_d  = 1'b0;
                cbe_oe_d = 1'b1;
                ad_oe_d  = 1'b1;
                cbe_d    = {3'b101, we_d};
                ad_d     = {16'h0001 << dev_d, 8'h00, reg_d, 2'b00};
                idsel_d  = (dev_d == 4'd0);
            end
            DATA: begin
                irdy_d   = 1'b0;
                cbe_oe_d = 1'b1;
                cbe_d    = ~be_d;
                ad_oe_d  = we_d;
                ad_d     = we_d ? wdata_d : 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pci_clk_i) begin
        if (!pci_rst_ni) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            dev_q         <= 4'd0;
            reg_q         <= 6'd0;
            be_q          <= 4'd0;
            wdata_q       <= 32'h0;
            devsel_seen_q <= 1'b0;
            abort_tmr_q   <= ABORT_LOAD;
`ifdef PCI_CFG_TIMEOUT_EN
            trdy_tmr_q    <= TRDY_LOAD;
`endif
            err_o         <= 2'b00;
            rdata_o       <= 32'h0;
            pci_frame_no  <= 1'b1;
            pci_irdy_no   <= 1'b1;
            pci_cbe_no    <= 4'hF;
            pci_cbe_oe_o  <= 1'b0;
            pci_ad_o      <= 32'h0;
            pci_ad_oe_o   <= 1'b0;
            pci_idsel_o   <= 1'b0;
            busy_o        <= 1'b0;
            ack_o         <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            dev_q         <= dev_d;
            reg_q         <= reg_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            devsel_seen_q <= devsel_seen_d;
            abort_tmr_q   <= abort_tmr_d;
`ifdef PCI_CFG_TIMEOUT_EN
            trdy_tmr_q    <= trdy_tmr_d;
`endif
            err_o         <= err_d;
            rdata_o       <= rdata_d;
            pci_frame_no  <= frame_d;
            pci_irdy_no   <= irdy_d;
            pci_cbe_no    <= cbe_d;
            pci_cbe_oe_o  <= cbe_oe_d;
            pci_ad_o      <= ad_d;
            pci_ad_oe_o   <= ad_oe_d;
            pci_idsel_o   <= idsel_d;
            busy_o        <= busy_d;
            ack_o         <= ack_d;
        end
    end

endmodule

// File: tb/tb_pci_cfg_initiator.sv
// Scoreboard bench for pci_cfg_initiator: scripted PCI target, expected responses queued at issue time.
module tb_pci_cfg_initiator;
    localparam int ABORT_CLKS = 5;
    localparam int TRDY_LIMIT = 16;

    localparam int K_NONE   = 0;
    localparam int K_OK     = 1;
    localparam int K_RETRY  = 2;
    localparam int K_TABORT = 3;
    localparam int K_BLIP   = 4;
    localparam int K_HANG   = 5;

    logic        pci_clk = 1'b0;
    logic        pci_rst_n;
    logic        req, we;
    logic [3:0]  dev, be;
    logic [5:0]  rg;
    logic [31:0] wdata;
    logic        busy_o, ack_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        pci_frame_no, pci_irdy_no, pci_cbe_oe_o, pci_ad_oe_o, pci_idsel_o;
    logic [3:0]  pci_cbe_no;
    logic [31:0] pci_ad_o, pci_ad_i;
    logic        pci_devsel_ni, pci_trdy_ni, pci_stop_ni;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rd;
        bit          chk_rd;
        int          lat;
        int          issue;
    } resp_t;

    typedef struct {
        logic [31:0] ad;
        logic [3:0]  cbe;
        bit          idsel;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wd;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;

    int          tgt_kind = K_NONE;
    int          tgt_dly = 0;
    int          tgt_wait = 0;
    logic [31:0] tgt_data = 32'h0;

    pci_cfg_initiator #(.ABORT_CLKS(ABORT_CLKS), .TRDY_LIMIT(TRDY_LIMIT)) dut (
        .pci_clk_i    (pci_clk),
        .pci_rst_ni   (pci_rst_n),
        .req_i        (req),
        .we_i         (we),
        .dev_i        (dev),
        .reg_i        (rg),
        .be_i         (be),
        .wdata_i      (wdata),
        .busy_o       (busy_o),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .rdata_o      (rdata_o),
        .pci_frame_no (pci_frame_no),
        .pci_irdy_no  (pci_irdy_no),
        .pci_cbe_no   (pci_cbe_no),
        .pci_cbe_oe_o (pci_cbe_oe_o),
        .pci_ad_o     (pci_ad_o),
        .pci_ad_oe_o  (pci_ad_oe_o),
        .pci_ad_i     (pci_ad_i),
        .pci_idsel_o  (pci_idsel_o),
        .pci_devsel_ni(pci_devsel_ni),
        .pci_trdy_ni  (pci_trdy_ni),
        .pci_stop_ni  (pci_stop_ni)
    );

    always #5 pci_clk = ~pci_clk;
    always @(posedge pci_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: status and req-to-ack latency follow from how the target behaves.
    task automatic model(input int kind, input int dly, input int wt, input bit wr, input logic [31:0] data,
                         output resp_t r);
        r.rd = 32'hFFFF_FFFF;
        r.chk_rd = 1'b0;
        r.lat = 3 + dly + wt;
        case (kind)
            K_NONE:   begin r.err = 2'b01; r.lat = ABORT_CLKS + 2; r.chk_rd = 1'b1; end
            K_OK,
            K_BLIP:   begin r.err = 2'b00; r.rd = data; r.chk_rd = !wr; end
            K_RETRY:  r.err = 2'b10;
            K_TABORT: r.err = 2'b11;
            default:  begin r.err = 2'b11; r.lat = 3 + dly + TRDY_LIMIT - 1; r.chk_rd = 1'b1; end
        endcase
        r.issue = cyc;
    endtask

    task automatic drive_target(input int k);
        logic dv, tr, st;
        dv = 1'b1; tr = 1'b1; st = 1'b1;
        case (tgt_kind)
            K_OK:     begin dv = !(k >= tgt_dly); tr = !(k == tgt_dly + tgt_wait); end
            K_RETRY:  begin dv = !(k >= tgt_dly); st = !(k == tgt_dly + tgt_wait); end
            K_TABORT: begin
                dv = !(k >= tgt_dly && k < tgt_dly + tgt_wait);
                st = !(k == tgt_dly + tgt_wait);
            end
            K_BLIP:   begin
                dv = !(k == tgt_dly || k == tgt_dly + tgt_wait);
                tr = !(k == tgt_dly + tgt_wait);
            end
            K_HANG:   dv = !(k >= tgt_dly);
            default:  ;
        endcase
        pci_devsel_ni = dv;
        pci_trdy_ni   = tr;
        pci_stop_ni   = st;
        pci_ad_i      = tr ? $urandom() : tgt_data;
    endtask

    // target: sample index k is driven on the negedge before the k-th DATA-phase rising edge
    initial begin
        pci_devsel_ni = 1'b1; pci_trdy_ni = 1'b1; pci_stop_ni = 1'b1; pci_ad_i = 32'h0;
        forever begin
            @(negedge pci_clk);
            if (!pci_frame_no) begin
                for (int k = 0; k < 400; k++) begin
                    @(negedge pci_clk);
                    if (pci_irdy_no) break;
                    drive_target(k);
                end
                pci_devsel_ni = 1'b1; pci_trdy_ni = 1'b1; pci_stop_ni = 1'b1;
            end
        end
    end

    // response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge pci_clk);
            if (ack_o) begin
                if (resp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_ack: got ack_o=1 expected no pending request (cycle %0d)", cyc);
                end else begin
                    r = resp_q.pop_front();
                    check("ack_err", 32'(err_o), 32'(r.err));
                    check("ack_latency", 32'(cyc - r.issue), 32'(r.lat));
                    if (r.chk_rd) check("ack_rdata", rdata_o, r.rd);
                end
            end
        end
    end

    // bus monitor: address phase then first data-phase clock
    initial begin
        bus_t cb;
        bit prev_frame_n, dchk;
        logic [3:0] exp_cbe;
        prev_frame_n = 1'b1;
        dchk = 1'b0;
        forever begin
            @(negedge pci_clk);
            if (dchk) begin
                dchk = 1'b0;
                exp_cbe = ~cb.be;
                check("data_irdy", 32'(pci_irdy_no), 32'(0));
                check("data_frame", 32'(pci_frame_no), 32'(1));
                check("data_cbe", 32'(pci_cbe_no), 32'(exp_cbe));
                check("data_ad_oe", 32'(pci_ad_oe_o), 32'(cb.we));
                if (cb.we) check("data_wdata", pci_ad_o, cb.wd);
            end
            if (!pci_frame_no && prev_frame_n) begin
                if (bus_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_addr: got FRAME# low expected idle bus (cycle %0d)", cyc);
                end else begin
                    cb = bus_q.pop_front();
                    check("addr_ad", pci_ad_o, cb.ad);
                    check("addr_cbe", 32'(pci_cbe_no), 32'(cb.cbe));
                    check("addr_idsel", 32'(pci_idsel_o), 32'(cb.idsel));
                    check("addr_oe", 32'({pci_ad_oe_o, pci_cbe_oe_o}), 32'(2'b11));
                    dchk = 1'b1;
                end
            end
            prev_frame_n = pci_frame_no;
        end
    end

    task automatic run_txn(input int kind, input bit wr, input logic [3:0] d, input logic [5:0] r,
                           input logic [3:0] b, input logic [31:0] wd, input int dly, input int wt,
                           input logic [31:0] data, input bit spurious, input bit expect_ack);
        bus_t  bx;
        resp_t rx;
        tgt_kind = kind; tgt_dly = dly; tgt_wait = wt; tgt_data = data;
        bx.ad    = (32'd1 << (16 + int'(d))) | {24'd0, r, 2'b00};
        bx.cbe   = wr ? 4'b1011 : 4'b1010;
        bx.idsel = (d == 4'd0);
        bx.be    = b;
        bx.we    = wr;
        bx.wd    = wd;
        bus_q.push_back(bx);
        if (expect_ack) begin
            model(kind, dly, wt, wr, data, rx);
            resp_q.push_back(rx);
        end
        req = 1'b1; we = wr; dev = d; rg = r; be = b; wdata = wd;
        @(negedge pci_clk);
        if (spurious) begin
            we = !wr; dev = d + 4'd1; rg = ~r; be = ~b; wdata = ~wd;
            @(negedge pci_clk);
        end
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge pci_clk);
            if (!busy_o) return;
        end
        n_checks++; n_fail++;
        $display("FAIL idle_timeout: got busy_o=1 after 300 clocks expected 0");
    endtask

    task automatic pulse_reset_and_check(input string tag);
        pci_rst_n = 1'b0;
        @(negedge pci_clk);
        check({tag, "_frame"}, 32'(pci_frame_no), 32'(1));
        check({tag, "_irdy"}, 32'(pci_irdy_no), 32'(1));
        check({tag, "_oe"}, 32'({pci_ad_oe_o, pci_cbe_oe_o}), 32'(0));
        check({tag, "_busy"}, 32'(busy_o), 32'(0));
        pci_rst_n = 1'b1;
        repeat (10) @(negedge pci_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, dly, wt;
        pci_rst_n = 1'b0;
        req = 1'b0; we = 1'b0; dev = 4'd0; rg = 6'd0; be = 4'd0; wdata = 32'h0;
        repeat (3) @(negedge pci_clk);
        check("rst_frame", 32'(pci_frame_no), 32'(1));
        check("rst_irdy", 32'(pci_irdy_no), 32'(1));
        check("rst_oe", 32'({pci_ad_oe_o, pci_cbe_oe_o}), 32'(0));
        check("rst_idsel", 32'(pci_idsel_o), 32'(0));
        check("rst_busy_ack", 32'({busy_o, ack_o}), 32'(0));
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_ad", pci_ad_o, 32'h0);
        check("rst_cbe", 32'(pci_cbe_no), 32'hF);
        pci_rst_n = 1'b1;
        @(negedge pci_clk);

        // directed cases
        run_txn(K_OK, 1'b0, 4'd0, 6'd0, 4'hF, 32'h0, 0, 1, 32'h9500_106D, 1'b0, 1'b1);
        wait_idle();
        run_txn(K_OK, 1'b1, 4'd1, 6'd4, 4'hF, 32'hFFFF_F000, 1, 0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        run_txn(K_NONE, 1'b0, 4'd3, 6'd9, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        run_txn(K_RETRY, 1'b0, 4'd2, 6'd1, 4'h3, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        run_txn(K_BLIP, 1'b0, 4'd5, 6'd2, 4'hF, 32'h0, 3, 4, 32'h1234_5678, 1'b0, 1'b1);
        wait_idle();

        // reset while in the data phase: bus released, no ack
        run_txn(K_NONE, 1'b0, 4'd2, 6'd3, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge pci_clk);
        check("rstmid_in_data", 32'(pci_irdy_no), 32'(0));
        pulse_reset_and_check("rstmid");

        // claiming target that never answers
`ifdef PCI_CFG_TIMEOUT_EN
        run_txn(K_HANG, 1'b0, 4'd6, 6'd7, 4'hF, 32'h0, 1, 0, 32'h0, 1'b0, 1'b1);
        wait_idle();
`else
        run_txn(K_HANG, 1'b0, 4'd6, 6'd7, 4'hF, 32'h0, 1, 0, 32'h0, 1'b0, 1'b0);
        repeat (100) @(negedge pci_clk);
        check("hang_still_busy", 32'(busy_o), 32'(1));
        pulse_reset_and_check("hang_rst");
`endif

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 7))
                0:       kind = K_NONE;
                1:       kind = K_RETRY;
                2:       kind = K_TABORT;
                3:       kind = K_BLIP;
                default: kind = K_OK;
            endcase
            dly = $urandom_range(0, 3);
            wt  = (kind == K_TABORT || kind == K_BLIP) ? $urandom_range(1, 4) : $urandom_range(0, 4);
            run_txn(kind, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                    4'($urandom_range(0, 15)), $urandom(), dly, wt, $urandom(),
                    ($urandom_range(0, 3) == 0), 1'b1);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge pci_clk);
        end

        repeat (5) @(negedge pci_clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'(0));
        check("bus_q_drained", 32'(bus_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
